// File: rtl/muldiv_seq_if.sv
// Operation interface for the sequential multiplier/divider.
//
// Handshake: the requester raises start for one cycle with op/a/b valid; the
// request is taken on that rising edge when busy is low. While busy is high
// further starts are dropped (no queueing). done pulses for exactly one cycle
// when hi/lo/dz carry a fresh result; abort cancels a running operation and
// produces no done.
interface muldiv_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             abort;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             dz;

   modport master (
      output start, op, a, b, abort,
      input  busy, done, hi, lo, dz
   );

   modport slave (
      input  start, op, a, b, abort,
      output busy, done, hi, lo, dz
   );
endinterface

// File: rtl/muldiv_seq.sv
// Sequential unsigned multiplier (shift-add) and divider (restoring), one
// iteration per cycle, WIDTH iterations per operation. Results are only
// published on completion; working registers stay internal.
module muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         reset,
   muldiv_seq_if.slave  bus,
   output logic [1:0]   dbg_state
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic             op_r;
   logic [WIDTH-1:0] opnd;    // multiplicand (mult) or divisor (div)
   logic [WIDTH-1:0] w_hi;    // accumulator upper half / partial remainder
   logic [WIDTH-1:0] w_lo;    // multiplier bits / dividend-quotient bits
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] hi_r;
   logic [WIDTH-1:0] lo_r;
   logic             dz_r;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH+1:0] div_trial;
   logic [WIDTH-1:0] nxt_hi;
   logic [WIDTH-1:0] nxt_lo;

   // One iteration of the selected algorithm on the working registers.
   always_comb begin
      mul_sum   = '0;
      div_shift = '0;
      div_trial = '0;
      nxt_hi    = w_hi;
      nxt_lo    = w_lo;
      if (!op_r) begin
         // Add the multiplicand when the current multiplier bit is set, then
         // shift the whole accumulator right by one (carry enters at top).
         mul_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, opnd} : '0);
         nxt_hi  = mul_sum[WIDTH:1];
         nxt_lo  = {mul_sum[0], w_lo[WIDTH-1:1]};
      end else begin
         // Bring the next dividend bit into the remainder and try to subtract;
         // the extra top bit of the trial is the borrow. A zero divisor never
         // borrows, giving an all-ones quotient and remainder equal to a.
         div_shift = {w_hi, w_lo[WIDTH-1]};
         div_trial = {1'b0, div_shift} - {2'b00, opnd};
         if (!div_trial[WIDTH+1]) begin
            nxt_hi = div_trial[WIDTH-1:0];
            nxt_lo = {w_lo[WIDTH-2:0], 1'b1};
         end else begin
            nxt_hi = div_shift[WIDTH-1:0];
            nxt_lo = {w_lo[WIDTH-2:0], 1'b0};
         end
      end
   end

   // Control FSM, working registers and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= '0;
         op_r   <= 1'b0;
         opnd   <= '0;
         w_hi   <= '0;
         w_lo   <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         hi_r   <= '0;
         lo_r   <= '0;
         dz_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  state  <= RUN;
                  busy_r <= 1'b1;
                  cnt    <= '0;
                  op_r   <= bus.op;
                  w_hi   <= '0;
                  if (bus.op) begin
                     opnd <= bus.b;
                     w_lo <= bus.a;
                  end else begin
                     opnd <= bus.a;
                     w_lo <= bus.b;
                  end
               end else begin
                  state  <= IDLE;
                  busy_r <= 1'b0;
               end
            end
            RUN: begin
               if (bus.abort) begin
                  // Cancel: published results are left untouched.
                  state  <= IDLE;
                  busy_r <= 1'b0;
               end else begin
                  w_hi <= nxt_hi;
                  w_lo <= nxt_lo;
                  if (cnt == CW'(WIDTH - 1)) begin
                     state  <= DONE;
                     busy_r <= 1'b0;
                     done_r <= 1'b1;
                     hi_r   <= nxt_hi;
                     lo_r   <= nxt_lo;
                     dz_r   <= op_r && (opnd == '0);
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            default: begin
               state  <= IDLE;
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy  = busy_r;
   assign bus.done  = done_r;
   assign bus.hi    = hi_r;
   assign bus.lo    = lo_r;
   assign bus.dz    = dz_r;
   assign dbg_state = state;

endmodule
